// File: rtl/crc_pkg.sv
// Shared CRC-16 definitions for the serial CRC generator and checker state machines.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV_DATA,
    RECV_CRC,
    CHECK
  } crc_chk_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int unsigned DATA_BITS  = 16;
  localparam int unsigned CRC_BITS   = 16;

endpackage

// File: rtl/crc16_serial_divider.sv
// Bit-serial CRC-16 polynomial divider, MSB-first, zero initial remainder.
module crc16_serial_divider
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CLEAR,
  input  logic        SHIFT_EN,
  input  logic        BIT_IN,
  output logic [15:0] REM
);

  logic [15:0] rem_q;
  logic [15:0] rem_d;

  always_comb begin
    rem_d = rem_q;
    if (CLEAR) begin
      rem_d = '0;
    end else if (SHIFT_EN) begin
      rem_d = {rem_q[14:0], BIT_IN} ^ (rem_q[15] ? POLY : 16'h0000);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign REM = rem_q;

endmodule

// File: rtl/crc_check_statemachine.sv
// Serial CRC-16 checker: receives 16 data bits + 16 CRC bits MSB-first and
// reports recovered data, received CRC, division remainder and pass/fail.
module crc_check_statemachine
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY    = CRC16_POLY,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        BIT_VALID,
  input  logic        BIT_IN,
  output logic [15:0] DATA_OUT,
  output logic [15:0] RECEIVED_CRC,
  output logic [15:0] REMAINDER,
  output logic        CRC_OK,
  output logic        TIMEOUT_ERR,
  output logic        DONE,
  output logic        BUSY
);

  localparam int unsigned IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [4:0]  DATA_LAST = 5'(DATA_BITS - 1);
  localparam logic [4:0]  CRC_LAST  = 5'(CRC_BITS - 1);

  crc_chk_state_t    state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0]       data_sr_q, data_sr_d;
  logic [15:0]       crc_sr_q, crc_sr_d;
  logic [15:0]       data_out_q, data_out_d;
  logic [15:0]       received_crc_q, received_crc_d;
  logic [15:0]       remainder_q, remainder_d;
  logic              crc_ok_q, crc_ok_d;
  logic              timeout_err_q, timeout_err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              div_clear;
  logic              div_shift;
  logic [15:0]       div_rem;

  crc16_serial_divider #(.POLY(POLY)) u_divider (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLEAR    (div_clear),
    .SHIFT_EN (div_shift),
    .BIT_IN   (BIT_IN),
    .REM      (div_rem)
  );

  // Next-state and next-output logic; START pre-empts whatever frame is in flight.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    data_sr_d      = data_sr_q;
    crc_sr_d       = crc_sr_q;
    data_out_d     = data_out_q;
    received_crc_d = received_crc_q;
    remainder_d    = remainder_q;
    crc_ok_d       = crc_ok_q;
    timeout_err_d  = timeout_err_q;
    done_d         = 1'b0;
    div_clear      = 1'b0;
    div_shift      = 1'b0;

    if (START) begin
      state_d       = RECV_DATA;
      bit_cnt_d     = '0;
      idle_cnt_d    = '0;
      crc_ok_d      = 1'b0;
      timeout_err_d = 1'b0;
      div_clear     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RECV_DATA, RECV_CRC: begin
          if (BIT_VALID) begin
            idle_cnt_d = '0;
            div_shift  = 1'b1;
            if (state_q == RECV_DATA) begin
              data_sr_d = {data_sr_q[14:0], BIT_IN};
              if (bit_cnt_q == DATA_LAST) begin
                bit_cnt_d = '0;
                state_d   = RECV_CRC;
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
              end
            end else begin
              crc_sr_d = {crc_sr_q[14:0], BIT_IN};
              if (bit_cnt_q == CRC_LAST) begin
                bit_cnt_d = '0;
                state_d   = CHECK;
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
              end
            end
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            // Abort keeps the previous frame's data, CRC and remainder visible.
            if ((TIMEOUT != 0) && (idle_cnt_d == IDLE_W'(TIMEOUT))) begin
              state_d       = IDLE;
              bit_cnt_d     = '0;
              idle_cnt_d    = '0;
              done_d        = 1'b1;
              timeout_err_d = 1'b1;
              crc_ok_d      = 1'b0;
            end
          end
        end
        CHECK: begin
          state_d        = IDLE;
          data_out_d     = data_sr_q;
          received_crc_d = crc_sr_q;
          remainder_d    = div_rem;
          crc_ok_d       = (div_rem == 16'h0000);
          timeout_err_d  = 1'b0;
          done_d         = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      data_sr_q      <= '0;
      crc_sr_q       <= '0;
      data_out_q     <= '0;
      received_crc_q <= '0;
      remainder_q    <= '0;
      crc_ok_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      data_sr_q      <= data_sr_d;
      crc_sr_q       <= crc_sr_d;
      data_out_q     <= data_out_d;
      received_crc_q <= received_crc_d;
      remainder_q    <= remainder_d;
      crc_ok_q       <= crc_ok_d;
      timeout_err_q  <= timeout_err_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  assign DATA_OUT     = data_out_q;
  assign RECEIVED_CRC = received_crc_q;
  assign REMAINDER    = remainder_q;
  assign CRC_OK       = crc_ok_q;
  assign TIMEOUT_ERR  = timeout_err_q;
  assign DONE         = done_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_crc_check_statemachine.sv
// Directed bench for the serial CRC-16 checker: vector table plus
// hand-written timeout, restart and reset sequences.
module tb_crc_check_statemachine;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        BIT_VALID;
  logic        BIT_IN;
  logic [15:0] DATA_OUT;
  logic [15:0] RECEIVED_CRC;
  logic [15:0] REMAINDER;
  logic        CRC_OK;
  logic        TIMEOUT_ERR;
  logic        DONE;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  crc_check_statemachine #(.POLY(16'h1021), .TIMEOUT(64)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .BIT_VALID    (BIT_VALID),
    .BIT_IN       (BIT_IN),
    .DATA_OUT     (DATA_OUT),
    .RECEIVED_CRC (RECEIVED_CRC),
    .REMAINDER    (REMAINDER),
    .CRC_OK       (CRC_OK),
    .TIMEOUT_ERR  (TIMEOUT_ERR),
    .DONE         (DONE),
    .BUSY         (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [15:0] data;
    logic [15:0] crc;
    int          gap;
    logic [15:0] exp_rem;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame();
    START     = 1'b1;
    BIT_VALID = 1'b0;
    tick();
    START = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] d, input logic [15:0] c, input int gap, input int nbits);
    logic [31:0] word;
    word = {d, c};
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < gap; g++) begin
        BIT_VALID = 1'b0;
        tick();
      end
      BIT_VALID = 1'b1;
      BIT_IN    = word[31-i];
      tick();
    end
    BIT_VALID = 1'b0;
    BIT_IN    = 1'b0;
  endtask

  // Called in cycle N+1 after the 32nd bit; leaves the bench in cycle N+2.
  task automatic check_result(input string tag, input logic [15:0] d, input logic [15:0] c,
                              input logic [15:0] rem, input logic ok);
    check({tag, " done_n1"}, 32'(DONE), 32'd0);
    check({tag, " busy_n1"}, 32'(BUSY), 32'd1);
    tick();
    check({tag, " done_n2"}, 32'(DONE), 32'd1);
    check({tag, " busy_n2"}, 32'(BUSY), 32'd0);
    check({tag, " data"}, 32'(DATA_OUT), 32'(d));
    check({tag, " rx_crc"}, 32'(RECEIVED_CRC), 32'(c));
    check({tag, " rem"}, 32'(REMAINDER), 32'(rem));
    check({tag, " crc_ok"}, 32'(CRC_OK), 32'(ok));
    check({tag, " tmo_err"}, 32'(TIMEOUT_ERR), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data"}, 32'(DATA_OUT), 32'd0);
    check({tag, " rx_crc"}, 32'(RECEIVED_CRC), 32'd0);
    check({tag, " rem"}, 32'(REMAINDER), 32'd0);
    check({tag, " crc_ok"}, 32'(CRC_OK), 32'd0);
    check({tag, " tmo_err"}, 32'(TIMEOUT_ERR), 32'd0);
    check({tag, " done"}, 32'(DONE), 32'd0);
    check({tag, " busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int d0;

    // data, crc, gap, expected remainder, expected CRC_OK
    vecs[0] = '{16'h0001, 16'h1021, 0, 16'h0000, 1'b1};
    vecs[1] = '{16'h0003, 16'h3063, 0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0002, 16'h2042, 0, 16'h0000, 1'b1};
    vecs[3] = '{16'h0001, 16'h1020, 3, 16'h0001, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0000, 16'hFFFF, 0, 16'hFFFF, 1'b0};
    vecs[6] = '{16'h0010, 16'h1231, 0, 16'h0000, 1'b1};
    vecs[7] = '{16'h0011, 16'h0210, 0, 16'h0000, 1'b1};
    vecs[8] = '{16'h0004, 16'h4084, 10, 16'h0000, 1'b1};

    RESET = 1'b1; START = 1'b0; BIT_VALID = 1'b0; BIT_IN = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b0;
    check_all_zero("reset");

    // Each frame's START coincides with the previous frame's DONE cycle.
    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      start_frame();
      check({tag, " busy_after_start"}, 32'(BUSY), 32'd1);
      check({tag, " ok_cleared"}, 32'(CRC_OK), 32'd0);
      send_bits(vecs[v].data, vecs[v].crc, vecs[v].gap, 32);
      check_result(tag, vecs[v].data, vecs[v].crc, vecs[v].exp_rem, vecs[v].exp_ok);
    end
    tick();
    check("last_done_pulse", 32'(DONE), 32'd0);

    // Timeout: 20 bits then 64 idle cycles; previous results must be held.
    start_frame();
    send_bits(16'hABCD, 16'h1234, 0, 20);
    for (int i = 0; i < 63; i++) tick();
    check("tmo done_early", 32'(DONE), 32'd0);
    check("tmo busy_early", 32'(BUSY), 32'd1);
    tick();
    check("tmo done", 32'(DONE), 32'd1);
    check("tmo err", 32'(TIMEOUT_ERR), 32'd1);
    check("tmo crc_ok", 32'(CRC_OK), 32'd0);
    check("tmo busy", 32'(BUSY), 32'd0);
    check("tmo data_held", 32'(DATA_OUT), 32'h0004);
    check("tmo crc_held", 32'(RECEIVED_CRC), 32'h4084);
    check("tmo rem_held", 32'(REMAINDER), 32'h0000);
    tick();
    check("tmo done_pulse", 32'(DONE), 32'd0);
    check("tmo err_hold", 32'(TIMEOUT_ERR), 32'd1);

    // Restart after 12 bits: only the second frame produces a DONE.
    tick();
    d0 = done_cnt;
    start_frame();
    check("restart err_cleared", 32'(TIMEOUT_ERR), 32'd0);
    send_bits(16'hFFFF, 16'hFFFF, 0, 12);
    start_frame();
    send_bits(16'h0002, 16'h2042, 0, 32);
    check_result("restart", 16'h0002, 16'h2042, 16'h0000, 1'b1);
    tick();
    check("restart done_count", 32'(done_cnt - d0), 32'd1);

    // Reset mid-frame: outputs return to zero, no DONE, stray bits ignored.
    start_frame();
    send_bits(16'h0003, 16'h3063, 0, 10);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_all_zero("midreset");
    d0 = done_cnt;
    send_bits(16'h0001, 16'h1021, 0, 32);
    tick(); tick();
    check("midreset no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset busy", 32'(BUSY), 32'd0);
    check("midreset data", 32'(DATA_OUT), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
